// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the gray sequence controller.
// Holds the FSM state enum, gray position table and requester count.
package gray_seq_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Position table, entry i is the pos value for index i.
    localparam logic [7:0][2:0] GRAY_POS = {
        3'b100, 3'b110, 3'b111, 3'b101,
        3'b001, 3'b011, 3'b010, 3'b000
    };

    function automatic logic [2:0] gray_of(input logic [2:0] idx);
        return GRAY_POS[idx];
    endfunction

endpackage

// File: rtl/gray_rr_arb.sv
// Two-way round-robin arbiter.
// Ports: req (requests), last (1 = requester 1 served last), win (one-hot).
module gray_rr_arb
    import gray_seq_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] win
);

    // A lone request always wins; on a tie the one not served last wins.
    always_comb begin
        win    = '0;
        win[0] = req[0] & (~req[1] | last);
        win[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Grants one requester a run of gray-counter steps, then pulses done.
// Ports: clk, rst (sync, active-high), req, cnt0, cnt1 -> gnt, busy,
// done, gcnt, pos. Optional abort input under GRAY_SEQ_ABORT_EN.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [STEP_W-1:0] cnt0,
    input  logic [STEP_W-1:0] cnt1,
`ifdef GRAY_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              done,
    output logic              gcnt,
    output logic [2:0]        pos
);

    localparam int REM_W = STEP_W + 1;

    seq_state_e        state;
    seq_state_e        nxt;
    logic [1:0]        owner;
    logic [1:0]        win;
    logic              last;
    logic [REM_W-1:0]  rem;
    logic [2:0]        idx;
    logic [STEP_W-1:0] sel_cnt;
    logic              stop;

    gray_rr_arb u_arb (
        .req  (req),
        .last (last),
        .win  (win)
    );

    assign sel_cnt = win[1] ? cnt1 : cnt0;

`ifdef GRAY_SEQ_ABORT_EN
    assign stop = abort || (rem == REM_W'(1));
`else
    assign stop = (rem == REM_W'(1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (|req) nxt = STEP;
            STEP:    if (stop) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath: grant owner, step budget, index, round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= '0;
            rem   <= '0;
            idx   <= '0;
            last  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= win;
                        // A zero count means the full 2^STEP_W steps.
                        rem   <= {(sel_cnt == '0), sel_cnt};
                    end
                end
                STEP: begin
                    rem <= rem - REM_W'(1);
                    idx <= idx + 3'd1;
                end
                DONE: last <= owner[1];
                default: ;
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        busy = (state != IDLE);
        gcnt = (state == STEP);
        done = (state == DONE);
        gnt  = gcnt ? owner : 2'b00;
        pos  = gray_of(idx);
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl.
// Define GRAY_SEQ_ABORT_EN to also exercise the abort input.
module tb_gray_seq_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [2:0] cnt0;
    logic [2:0] cnt1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       gcnt;
    logic [2:0] pos;
`ifdef GRAY_SEQ_ABORT_EN
    logic       abort;
`endif

    int passed;
    int total;

    logic [2:0] exp_pos [8];

    gray_seq_ctrl #(.STEP_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .cnt0 (cnt0),
        .cnt1 (cnt1),
`ifdef GRAY_SEQ_ABORT_EN
        .abort(abort),
`endif
        .gnt  (gnt),
        .busy (busy),
        .done (done),
        .gcnt (gcnt),
        .pos  (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count gcnt and done cycles from now until the block is idle.
    task automatic run_seq(input int max, output int gc, output int dn);
        int n;
        gc = 0;
        dn = 0;
        n  = 0;
        while (busy && n < max) begin
            if (gcnt) gc++;
            if (done) dn++;
            tick();
            n++;
        end
        check("seq_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int gc;
        int dn;
        passed = 0;
        total  = 0;
        exp_pos = '{3'b000, 3'b010, 3'b011, 3'b001,
                    3'b101, 3'b111, 3'b110, 3'b100};
        rst  = 1'b1;
        req  = 2'b00;
        cnt0 = 3'd0;
        cnt1 = 3'd0;
`ifdef GRAY_SEQ_ABORT_EN
        abort = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        check("rst_gnt",  {30'd0, gnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_gcnt", {31'd0, gcnt}, 32'd0);
        check("rst_pos",  {29'd0, pos}, 32'd0);
        rst = 1'b0;

        // Single requester 0, three steps
        req  = 2'b01;
        cnt0 = 3'd3;
        tick();
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("s1_gcnt", {31'd0, gcnt}, 32'd1);
            check("s1_gnt",  {30'd0, gnt}, 32'd1);
            check("s1_pos",  {29'd0, pos}, {29'd0, exp_pos[i]});
            tick();
        end
        check("s1_done",  {31'd0, done}, 32'd1);
        check("s1_dgcnt", {31'd0, gcnt}, 32'd0);
        check("s1_dgnt",  {30'd0, gnt}, 32'd0);
        check("s1_dpos",  {29'd0, pos}, 32'b001);
        tick();
        check("s1_idle", {31'd0, busy}, 32'd0);
        check("s1_ndone", {31'd0, done}, 32'd0);

        // Round robin with both requests held
        do_reset();
        req  = 2'b11;
        cnt0 = 3'd1;
        cnt1 = 3'd2;
        tick();
        check("rr_g0", {30'd0, gnt}, 32'b01);
        tick();
        check("rr_d0", {31'd0, done}, 32'd1);
        tick();
        check("rr_i0", {31'd0, busy}, 32'd0);
        tick();
        check("rr_g1a", {30'd0, gnt}, 32'b10);
        tick();
        check("rr_g1b", {30'd0, gnt}, 32'b10);
        tick();
        check("rr_d1", {31'd0, done}, 32'd1);
        tick();
        check("rr_i1", {31'd0, busy}, 32'd0);
        tick();
        check("rr_g2", {30'd0, gnt}, 32'b01);
        req = 2'b00;
        tick();
        check("rr_d2", {31'd0, done}, 32'd1);
        tick();
        // index is now 1+2+1 = 4
        check("rr_pos", {29'd0, pos}, {29'd0, exp_pos[4]});

        // Count 0 on requester 1: full 8 steps, pos wraps
        req  = 2'b10;
        cnt1 = 3'd0;
        tick();
        check("wr_gnt", {30'd0, gnt}, 32'b10);
        req = 2'b00;
        run_seq(20, gc, dn);
        check("wr_steps", gc, 32'd8);
        check("wr_done",  dn, 32'd1);
        check("wr_pos",   {29'd0, pos}, {29'd0, exp_pos[4]});

        // Inputs changed mid-sequence are ignored
        req  = 2'b01;
        cnt0 = 3'd2;
        tick();
        req  = 2'b00;
        cnt0 = 3'd7;
        run_seq(20, gc, dn);
        check("ig_steps", gc, 32'd2);
        check("ig_done",  dn, 32'd1);
        check("ig_pos",   {29'd0, pos}, {29'd0, exp_pos[6]});

        // Reset in the third STEP cycle abandons the sequence
        req  = 2'b01;
        cnt0 = 3'd5;
        tick();
        req = 2'b00;
        tick();
        tick();
        check("ra_step3", {31'd0, gcnt}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ra_gcnt", {31'd0, gcnt}, 32'd0);
        check("ra_done", {31'd0, done}, 32'd0);
        check("ra_busy", {31'd0, busy}, 32'd0);
        check("ra_gnt",  {30'd0, gnt}, 32'd0);
        check("ra_pos",  {29'd0, pos}, 32'd0);
        tick();
        check("ra_nodone", {31'd0, done}, 32'd0);
        check("ra_idle",   {31'd0, busy}, 32'd0);

`ifdef GRAY_SEQ_ABORT_EN
        // Abort in the second STEP cycle
        do_reset();
        req  = 2'b01;
        cnt0 = 3'd6;
        tick();
        req = 2'b00;
        check("ab_s1", {31'd0, gcnt}, 32'd1);
        tick();
        check("ab_s2", {31'd0, gcnt}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_done", {31'd0, done}, 32'd1);
        check("ab_gcnt", {31'd0, gcnt}, 32'd0);
        check("ab_pos",  {29'd0, pos}, 32'b011);
        tick();
        check("ab_idle", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
